// File: rtl/timer_regs.sv
`default_nettype none
// timer_regs (rev 1.0): Timer register bank, prescaled 64-bit up-counter, 64-bit compare, sticky interrupt.
// Define TIMER_HALT_EN to add the THCSR debug-halt control; otherwise THCSR reads 0 and dbg_mode is ignored.
module timer_regs #(
  parameter int          ADDR_W  = 12,
  parameter logic [63:0] CNT_RST = 64'h0,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] tim_paddr,
  input  logic [31:0]       tim_pwdata,
  input  logic [3:0]        tim_pstrb,
  input  logic              dbg_mode,
  output logic [31:0]       tim_prdata,
  output logic              reg_error_flag,
  output logic              tim_int
);

  localparam logic [ADDR_W-1:0] A_TCR   = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_TDR0  = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_TDR1  = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_TCMP0 = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] A_TCMP1 = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] A_TIER  = ADDR_W'(32'h14);
  localparam logic [ADDR_W-1:0] A_TISR  = ADDR_W'(32'h18);
  localparam logic [ADDR_W-1:0] A_THCSR = ADDR_W'(32'h1C);

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

  logic        timer_en;
  logic        div_en;
  logic [3:0]  div_val;
  logic [7:0]  div_cnt;
  logic [63:0] cnt;
  logic [63:0] cmp;
  logic        int_en;
  logic        int_st;
  logic        halted;
  logic [31:0] thcsr_word;

  logic we_tcr, we_tdr0, we_tdr1, we_tcmp0, we_tcmp1, we_tier, we_tisr;
  assign we_tcr   = wr_en && (tim_paddr == A_TCR);
  assign we_tdr0  = wr_en && (tim_paddr == A_TDR0);
  assign we_tdr1  = wr_en && (tim_paddr == A_TDR1);
  assign we_tcmp0 = wr_en && (tim_paddr == A_TCMP0);
  assign we_tcmp1 = wr_en && (tim_paddr == A_TCMP1);
  assign we_tier  = wr_en && (tim_paddr == A_TIER);
  assign we_tisr  = wr_en && (tim_paddr == A_TISR);

  // Candidate TCR contents after the byte-lane merge; only lanes 0 and 1 carry fields.
  logic       new_timer_en;
  logic       new_div_en;
  logic [3:0] new_div_val;
  logic       tcr_illegal;
  assign new_timer_en = tim_pstrb[0] ? tim_pwdata[0]    : timer_en;
  assign new_div_en   = tim_pstrb[0] ? tim_pwdata[1]    : div_en;
  assign new_div_val  = tim_pstrb[1] ? tim_pwdata[11:8] : div_val;
  assign tcr_illegal  = (new_div_val > 4'd8) ||
                        (((new_div_en != div_en) || (new_div_val != div_val)) &&
                         (timer_en || new_timer_en));

  assign reg_error_flag = we_tcr && tcr_illegal;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      timer_en <= 1'b0;
      div_en   <= 1'b0;
      div_val  <= 4'd1;
    end else if (we_tcr && !tcr_illegal) begin
      timer_en <= new_timer_en;
      div_en   <= new_div_en;
      div_val  <= new_div_val;
    end
  end

`ifdef TIMER_HALT_EN
  logic halt_req;
  logic halt_ack;
  assign halt_ack   = halt_req & dbg_mode;
  assign halted     = halt_ack;
  assign thcsr_word = {30'b0, halt_ack, halt_req};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      halt_req <= 1'b0;
    end else if (wr_en && (tim_paddr == A_THCSR) && tim_pstrb[0]) begin
      halt_req <= tim_pwdata[0];
    end
  end
`else
  logic unused_dbg;
  assign unused_dbg = dbg_mode;
  assign halted     = 1'b0;
  assign thcsr_word = 32'h0;
`endif

  // Terminal count is 2^div_val - 1; div_val never exceeds 8, so it fits the 8-bit prescaler.
  logic [8:0] div_limit;
  logic       tick;
  assign div_limit = (9'd1 << div_val) - 9'd1;
  assign tick      = div_en ? ({1'b0, div_cnt} == div_limit) : 1'b1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !timer_en || !div_en) begin
      div_cnt <= 8'd0;
    end else if (!halted) begin
      div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt <= CNT_RST;
    end else if (we_tdr0) begin
      cnt[31:0] <= merge_lanes(cnt[31:0], tim_pwdata, tim_pstrb);
    end else if (we_tdr1) begin
      cnt[63:32] <= merge_lanes(cnt[63:32], tim_pwdata, tim_pstrb);
    end else if (timer_en && tick && !halted) begin
      cnt <= cnt + 64'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cmp <= CMP_RST;
    end else if (we_tcmp0) begin
      cmp[31:0] <= merge_lanes(cmp[31:0], tim_pwdata, tim_pstrb);
    end else if (we_tcmp1) begin
      cmp[63:32] <= merge_lanes(cmp[63:32], tim_pwdata, tim_pstrb);
    end
  end

  // A compare hit on the same edge as a software clear keeps the flag set.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      int_st <= 1'b0;
      int_en <= 1'b0;
    end else begin
      if (cnt == cmp) begin
        int_st <= 1'b1;
      end else if (we_tisr && tim_pstrb[0] && tim_pwdata[0]) begin
        int_st <= 1'b0;
      end
      if (we_tier && tim_pstrb[0]) begin
        int_en <= tim_pwdata[0];
      end
    end
  end

  assign tim_int = int_st & int_en;

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = 32'h0;
    case (tim_paddr)
      A_TCR:   rd_mux = {20'b0, div_val, 6'b0, div_en, timer_en};
      A_TDR0:  rd_mux = cnt[31:0];
      A_TDR1:  rd_mux = cnt[63:32];
      A_TCMP0: rd_mux = cmp[31:0];
      A_TCMP1: rd_mux = cmp[63:32];
      A_TIER:  rd_mux = {31'b0, int_en};
      A_TISR:  rd_mux = {31'b0, int_st};
      A_THCSR: rd_mux = thcsr_word;
      default: rd_mux = 32'h0;
    endcase
  end

  assign tim_prdata = rd_en ? rd_mux : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_timer_regs.sv
`default_nettype none
// tb_timer_regs: directed plus randomized stimulus for timer_regs, checked every cycle against a
// cycle-level reference model of the register map, prescaler, counter and interrupt rules.
module tb_timer_regs;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [11:0] tim_paddr = 12'h0;
  logic [31:0] tim_pwdata = 32'h0;
  logic [3:0]  tim_pstrb = 4'h0;
  logic        dbg_mode = 1'b0;
  logic [31:0] tim_prdata;
  logic        reg_error_flag;
  logic        tim_int;

  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  timer_regs #(.ADDR_W(12)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(wr_en), .rd_en(rd_en),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .dbg_mode(dbg_mode), .tim_prdata(tim_prdata), .reg_error_flag(reg_error_flag),
    .tim_int(tim_int)
  );

  // ---------------- reference model ----------------
  logic [63:0] m_cnt, m_cmp;
  bit          m_ten, m_den, m_ien, m_ist, m_hreq;
  bit          m_valid = 1'b0;
  int          m_dval, m_phase;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] apply_lanes(input logic [31:0] old_val,
                                              input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_tcr();
    return {20'b0, 4'(m_dval), 6'b0, m_den, m_ten};
  endfunction

  function automatic bit m_halted();
`ifdef TIMER_HALT_EN
    return m_hreq && dbg_mode;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_tcr_bad(input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] nw;
    int nd;
    nw = apply_lanes(m_tcr(), wd, s);
    nd = int'(nw[11:8]);
    return (nd > 8) || (((nw[1] != m_den) || (nd != m_dval)) && (m_ten || nw[0]));
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h000: return m_tcr();
      12'h004: return m_cnt[31:0];
      12'h008: return m_cnt[63:32];
      12'h00C: return m_cmp[31:0];
      12'h010: return m_cmp[63:32];
      12'h014: return {31'b0, m_ien};
      12'h018: return {31'b0, m_ist};
`ifdef TIMER_HALT_EN
      12'h01C: return {30'b0, m_halted(), m_hreq};
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_cnt = 64'h0; m_cmp = '1; m_ten = 0; m_den = 0; m_dval = 1;
      m_ien = 0; m_ist = 0; m_hreq = 0; m_phase = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      bit hit, halted, tick, wr_tdr, bad;
      hit    = (m_cnt == m_cmp);
      halted = m_halted();
      tick   = !m_den || (m_phase == (1 << m_dval) - 1);
      wr_tdr = wr_en && (tim_paddr == 12'h004 || tim_paddr == 12'h008);
      bad    = m_tcr_bad(tim_pwdata, tim_pstrb);
      if (m_ten && !halted && tick && !wr_tdr) m_cnt = m_cnt + 64'd1;
      if (!m_ten || !m_den) m_phase = 0;
      else if (!halted) m_phase = tick ? 0 : m_phase + 1;
      if (hit) m_ist = 1'b1;
      else if (wr_en && tim_paddr == 12'h018 && tim_pstrb[0] && tim_pwdata[0]) m_ist = 1'b0;
      if (wr_en) begin
        case (tim_paddr)
          12'h000: if (!bad) begin
            logic [31:0] nw;
            nw = apply_lanes(m_tcr(), tim_pwdata, tim_pstrb);
            m_ten = nw[0]; m_den = nw[1]; m_dval = int'(nw[11:8]);
          end
          12'h004: m_cnt[31:0]  = apply_lanes(m_cnt[31:0], tim_pwdata, tim_pstrb);
          12'h008: m_cnt[63:32] = apply_lanes(m_cnt[63:32], tim_pwdata, tim_pstrb);
          12'h00C: m_cmp[31:0]  = apply_lanes(m_cmp[31:0], tim_pwdata, tim_pstrb);
          12'h010: m_cmp[63:32] = apply_lanes(m_cmp[63:32], tim_pwdata, tim_pstrb);
          12'h014: if (tim_pstrb[0]) m_ien = tim_pwdata[0];
          12'h01C: if (tim_pstrb[0]) m_hreq = tim_pwdata[0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge sys_clk) begin
    #2;
    if (m_valid) begin
      chk("prdata", 64'(tim_prdata), 64'(rd_en ? m_read(tim_paddr) : 32'h0));
      chk("err", 64'(reg_error_flag),
          64'(wr_en && tim_paddr == 12'h000 && m_tcr_bad(tim_pwdata, tim_pstrb)));
      chk("int", 64'(tim_int), 64'(m_ist && m_ien));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit rst, input bit w, input bit r, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    @(negedge sys_clk);
    sys_rst = rst; wr_en = w; rd_en = r; tim_paddr = a; tim_pwdata = d; tim_pstrb = s;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    drive(1'b0, 1'b1, 1'b0, a, d, s);
  endtask

  task automatic rd_lit(input string nm, input logic [11:0] a, input logic [31:0] exp);
    drive(1'b0, 1'b0, 1'b1, a, 32'h0, 4'h0);
    #2 chk(nm, 64'(tim_prdata), 64'(exp));
  endtask

  task automatic wr_err(input string nm, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit exp);
    wr(a, d, s);
    #2 chk(nm, 64'(reg_error_flag), 64'(exp));
  endtask

  initial begin
    // Reset values
    do_reset();
    rd_lit("rst_tcr", 12'h000, 32'h100);
    rd_lit("rst_tcmp0", 12'h00C, 32'hFFFF_FFFF);
    rd_lit("rst_tcmp1", 12'h010, 32'hFFFF_FFFF);
    rd_lit("rst_tdr0", 12'h004, 32'h0);
    rd_lit("rst_tdr1", 12'h008, 32'h0);
    chk("rst_int", 64'(tim_int), 64'h0);

    // Plain counting, then stop and hold
    wr(12'h000, 32'h1, 4'b0001);
    idle(10);
    rd_lit("cnt10", 12'h004, 32'd10);
    wr(12'h000, 32'h0, 4'b0001);
    idle(3);
    rd_lit("cnt_hold", 12'h004, 32'd12);
    rd_lit("tcr_off", 12'h000, 32'h100);

    // Prescaler by 4 and TCR error rules
    do_reset();
    wr_err("cfg_div", 12'h000, 32'h202, 4'hF, 1'b0);
    wr_err("en_div", 12'h000, 32'h203, 4'hF, 1'b0);
    idle(40);
    rd_lit("div4_cnt", 12'h004, 32'd10);
    wr_err("chg_running", 12'h000, 32'h303, 4'hF, 1'b1);
    rd_lit("tcr_kept", 12'h000, 32'h203);
    wr_err("div9_running", 12'h000, 32'h903, 4'hF, 1'b1);
    wr_err("stop", 12'h000, 32'h202, 4'hF, 1'b0);
    wr_err("div9_idle", 12'h000, 32'h900, 4'hF, 1'b1);
    wr_err("div8_idle", 12'h000, 32'h800, 4'hF, 1'b0);
    rd_lit("tcr_div8", 12'h000, 32'h800);
    wr_err("unmapped_wr", 12'h020, 32'hFFFF_FFFF, 4'hF, 1'b0);
    rd_lit("unmapped_rd", 12'h020, 32'h0);

    // 64-bit wrap and compare interrupt
    do_reset();
    wr(12'h008, 32'hFFFF_FFFF, 4'hF);
    wr(12'h004, 32'hFFFF_FFFE, 4'hF);
    wr(12'h00C, 32'h0, 4'hF);
    wr(12'h010, 32'h0, 4'hF);
    wr(12'h014, 32'h1, 4'hF);
    wr(12'h000, 32'h1, 4'b0001);
    idle(3);
    rd_lit("wrap_tisr", 12'h018, 32'h1);
    chk("wrap_int", 64'(tim_int), 64'h1);
    rd_lit("wrap_tdr1", 12'h008, 32'h0);
    wr(12'h000, 32'h0, 4'b0001);
    wr(12'h018, 32'h1, 4'b0001);
    idle(1);
    #2 chk("int_cleared", 64'(tim_int), 64'h0);

    // Compare hit coinciding with a clear keeps the flag
    wr(12'h004, 32'd5, 4'hF);
    wr(12'h00C, 32'd5, 4'hF);
    idle(2);
    wr(12'h018, 32'h1, 4'b0001);
    idle(1);
    #2 chk("set_wins", 64'(tim_int), 64'h1);
    wr(12'h00C, 32'd6, 4'hF);
    wr(12'h018, 32'h1, 4'b0001);
    idle(1);
    #2 chk("clear_after", 64'(tim_int), 64'h0);

    // Reset mid-count
    wr(12'h000, 32'h1, 4'b0001);
    idle(5);
    do_reset();
    rd_lit("midrst_tdr0", 12'h004, 32'h0);
    rd_lit("midrst_tcr", 12'h000, 32'h100);
    idle(3);
    rd_lit("midrst_still", 12'h004, 32'h0);
    rd_lit("midrst_tier", 12'h014, 32'h0);

`ifdef TIMER_HALT_EN
    do_reset();
    wr(12'h01C, 32'h1, 4'b0001);
    dbg_mode = 1'b1;
    rd_lit("thcsr_ack", 12'h01C, 32'h3);
    wr(12'h000, 32'h1, 4'b0001);
    idle(5);
    rd_lit("halt_frozen", 12'h004, 32'h0);
    idle(1);
    dbg_mode = 1'b0;
    idle(3);
    rd_lit("halt_resume", 12'h004, 32'd4);
`else
    wr(12'h01C, 32'h1, 4'b0001);
    rd_lit("thcsr_zero", 12'h01C, 32'h0);
`endif

    // Randomized traffic checked by the model each cycle
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int op, sel;
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      op  = int'($urandom_range(0, 99));
      sel = int'($urandom_range(0, 10));
      case (sel)
        0: a = 12'h000;  1: a = 12'h004;  2: a = 12'h008;  3: a = 12'h00C;
        4: a = 12'h010;  5: a = 12'h014;  6: a = 12'h018;  7: a = 12'h01C;
        8: a = 12'h020;  9: a = 12'hFFC;  default: a = 12'h002;
      endcase
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      case (a)
        12'h000: d = ($urandom_range(0, 1) == 1) ? {20'b0, 4'($urandom_range(0, 9)), 6'b0,
                                                    2'($urandom_range(0, 3))} : $urandom;
        12'h004: d = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
        12'h008: d = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0;
        12'h00C: d = m_cnt[31:0] + $urandom_range(0, 40);
        12'h010: d = ($urandom_range(0, 3) != 0) ? m_cnt[63:32] : $urandom;
        default: d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1));
      endcase
      if (op < 2) do_reset();
      else if (op < 40) idle(1);
      else if (op < 65) drive(1'b0, 1'b0, 1'b1, a, 32'h0, 4'h0);
      else drive(1'b0, 1'b1, 1'b0, a, d, s);
      if ($urandom_range(0, 19) == 0) dbg_mode = ~dbg_mode;
    end

    idle(2);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
